// File: rtl/mem_stage_access_unit.sv
// MEM pipeline stage: runs word load/store transfers on a req/ack data bus,
// stalls upstream while a transfer is outstanding, and fills the MEM/WB register.
module mem_stage_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_read_MEM,
    input  logic        data_write_MEM,
    input  logic        reg_write_MEM,
    input  logic        write_Data_Src_mux_MEM,
    input  logic        Set_Less_than_inst_MEM,
    input  logic        STL_MEM,
    input  logic [31:0] Adderess_Datamem,
    input  logic [31:0] Write_Data_Datamem,
    input  logic [4:0]  Reg_write_num_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_MEM,
    output logic        reg_write_WB,
    output logic        write_Data_Src_mux_WB,
    output logic [4:0]  Reg_write_num_WB,
    output logic [31:0] ALU_result_WB,
    output logic [31:0] Mem_read_data_WB,
    output logic        mem_err
);

    // Bus handshake: dmem_req rises one edge after the op is seen and holds
    // req/we/addr/wdata constant until the cycle dmem_ack=1 (rdata valid in
    // that same cycle); req drops on the following edge. Ack with req low is ignored.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             mem_op, aligned, timeout_hit, finish;
    logic [31:0]      alu_value;

    assign mem_op      = data_read_MEM | data_write_MEM;
    assign aligned     = (Adderess_Datamem[1:0] == 2'b00);
    assign timeout_hit = (state == BUSY) && !dmem_ack && (cnt == CNT_W'(TIMEOUT - 1));
    assign finish      = (state == BUSY) && (dmem_ack || timeout_hit);
    assign alu_value   = Set_Less_than_inst_MEM ? {31'b0, STL_MEM} : Adderess_Datamem;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_MEM  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    stall_MEM  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall_MEM = !finish;
                if (finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt                   <= '0;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_addr             <= '0;
            dmem_wdata            <= '0;
            reg_write_WB          <= 1'b0;
            write_Data_Src_mux_WB <= 1'b0;
            Reg_write_num_WB      <= '0;
            ALU_result_WB         <= '0;
            Mem_read_data_WB      <= '0;
            mem_err               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        reg_write_WB <= 1'b0;
                        if (aligned) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= data_write_MEM;
                            dmem_addr  <= Adderess_Datamem;
                            dmem_wdata <= Write_Data_Datamem;
                            cnt        <= '0;
                        end else begin
                            mem_err <= 1'b1;
                        end
                    end else begin
                        reg_write_WB          <= reg_write_MEM;
                        write_Data_Src_mux_WB <= write_Data_Src_mux_MEM;
                        Reg_write_num_WB      <= Reg_write_num_MEM;
                        ALU_result_WB         <= alu_value;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        dmem_req              <= 1'b0;
                        reg_write_WB          <= reg_write_MEM & ~dmem_we;
                        write_Data_Src_mux_WB <= write_Data_Src_mux_MEM;
                        Reg_write_num_WB      <= Reg_write_num_MEM;
                        ALU_result_WB         <= alu_value;
                        if (dmem_ack) begin
                            if (!dmem_we) Mem_read_data_WB <= dmem_rdata;
                        end else begin
                            // forced completion: no data ever arrived
                            Mem_read_data_WB <= '0;
                            mem_err          <= 1'b1;
                        end
                    end else begin
                        cnt          <= cnt + 1'b1;
                        reg_write_WB <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit: expected MEM/WB contents are queued
// when each instruction is driven and compared when the stage writes MEM/WB.
module tb_mem_stage_access_unit;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_read_MEM, data_write_MEM, reg_write_MEM, write_Data_Src_mux_MEM;
    logic        Set_Less_than_inst_MEM, STL_MEM;
    logic [31:0] Adderess_Datamem, Write_Data_Datamem;
    logic [4:0]  Reg_write_num_MEM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_MEM, reg_write_WB, write_Data_Src_mux_WB, mem_err;
    logic [4:0]  Reg_write_num_WB;
    logic [31:0] ALU_result_WB, Mem_read_data_WB;

    logic [70:0] exp_q[$];
    logic [31:0] exp_mem;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    mem_stage_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .data_read_MEM(data_read_MEM), .data_write_MEM(data_write_MEM),
        .reg_write_MEM(reg_write_MEM), .write_Data_Src_mux_MEM(write_Data_Src_mux_MEM),
        .Set_Less_than_inst_MEM(Set_Less_than_inst_MEM), .STL_MEM(STL_MEM),
        .Adderess_Datamem(Adderess_Datamem), .Write_Data_Datamem(Write_Data_Datamem),
        .Reg_write_num_MEM(Reg_write_num_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_MEM(stall_MEM),
        .reg_write_WB(reg_write_WB), .write_Data_Src_mux_WB(write_Data_Src_mux_WB),
        .Reg_write_num_WB(Reg_write_num_WB), .ALU_result_WB(ALU_result_WB),
        .Mem_read_data_WB(Mem_read_data_WB), .mem_err(mem_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [70:0] wb_vec();
        return {reg_write_WB, write_Data_Src_mux_WB, Reg_write_num_WB, ALU_result_WB, Mem_read_data_WB};
    endfunction

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag);
        logic [70:0] e;
        if (exp_q.size() == 0) begin
            e = '1;
            check({tag, "_noexp"}, 71'(0), 71'(1));
        end else begin
            e = exp_q.pop_front();
            check(tag, wb_vec(), e);
        end
    endtask

    task automatic edge_in();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        data_read_MEM = 0; data_write_MEM = 0; reg_write_MEM = 0; write_Data_Src_mux_MEM = 0;
        Set_Less_than_inst_MEM = 0; STL_MEM = 0; Adderess_Datamem = 0; Write_Data_Datamem = 0;
        Reg_write_num_MEM = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // driver: non-memory instruction
    task automatic run_alu(input string tag, input logic [31:0] addr, input logic rw, input logic [4:0] rd,
                           input logic slt, input logic stl);
        data_read_MEM = 0; data_write_MEM = 0; reg_write_MEM = rw; write_Data_Src_mux_MEM = 0;
        Set_Less_than_inst_MEM = slt; STL_MEM = stl; Adderess_Datamem = addr; Reg_write_num_MEM = rd;
        exp_q.push_back({rw, 1'b0, rd, slt ? {31'b0, stl} : addr, exp_mem});
        @(negedge clk);
        check({tag, "_stall"}, 71'(stall_MEM), 71'(0));
        edge_in();
        check_wb(tag);
        check({tag, "_req"}, 71'(dmem_req), 71'(0));
    endtask

    // driver: load/store with a given number of wait cycles before ack
    task automatic run_mem(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int wait_n, input logic [4:0] rd);
        data_read_MEM = ~we; data_write_MEM = we; reg_write_MEM = 1; write_Data_Src_mux_MEM = ~we;
        Set_Less_than_inst_MEM = 0; STL_MEM = 0; Adderess_Datamem = addr; Write_Data_Datamem = wdata;
        Reg_write_num_MEM = rd;
        if (!we) exp_mem = rdata;
        exp_q.push_back({~we, ~we, rd, addr, exp_mem});
        @(negedge clk);
        check({tag, "_detect_stall"}, 71'(stall_MEM), 71'(1));
        check({tag, "_detect_req"}, 71'(dmem_req), 71'(0));
        edge_in();
        for (int i = 0; i <= wait_n; i++) begin
            dmem_ack = (i == wait_n);
            dmem_rdata = (i == wait_n) ? rdata : 32'hBAD0_0000 + 32'(i);
            @(negedge clk);
            check({tag, "_bus"}, {dmem_req, dmem_we, dmem_addr, 5'd0, dmem_wdata},
                  {1'b1, we, addr, 5'd0, wdata});
            check({tag, "_busy_stall"}, 71'(stall_MEM), 71'(i != wait_n));
            if (i < wait_n) check({tag, "_bubble"}, 71'(reg_write_WB), 71'(0));
            edge_in();
        end
        dmem_ack = 0;
        check_wb(tag);
        check({tag, "_req_drop"}, 71'(dmem_req), 71'(0));
    endtask

    initial begin
        reset = 1;
        drive_idle();
        exp_mem = 0;
        edge_in();
        edge_in();
        reset = 0;
        @(negedge clk);
        check("reset_wb", wb_vec(), 71'(0));
        check("reset_bus", {dmem_req, dmem_we, stall_MEM, mem_err, dmem_addr, dmem_wdata, 3'd0},
              71'(0));

        run_alu("alu", 32'h0000_0040, 1'b1, 5'd5, 1'b0, 1'b0);
        dmem_ack = 1;
        dmem_rdata = 32'h5555_5555;
        run_alu("slt_spurious_ack", 32'hFFFF_FFFF, 1'b1, 5'd6, 1'b1, 1'b1);
        dmem_ack = 0;
        run_alu("slt_zero", 32'h0000_0007, 1'b1, 5'd11, 1'b1, 1'b0);
        run_mem("load0", 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 5'd8);
        run_mem("store3", 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0, 3, 5'd9);
        run_mem("load2", 1'b0, 32'h0000_0104, 32'hABCD_0000, 32'h0BAD_F00D, 2, 5'd12);
        run_alu("alu_after", 32'h0000_0ABC, 1'b0, 5'd3, 1'b0, 1'b0);

        // load with no ack until forced completion
        data_read_MEM = 1; reg_write_MEM = 1; write_Data_Src_mux_MEM = 1;
        Adderess_Datamem = 32'h0000_0300; Reg_write_num_MEM = 5'd10;
        exp_mem = 0;
        exp_q.push_back({1'b1, 1'b1, 5'd10, 32'h0000_0300, 32'h0});
        edge_in();
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            check("tmo_req", 71'(dmem_req), 71'(1));
            check("tmo_stall", 71'(stall_MEM), 71'(i != TIMEOUT - 1));
            check("tmo_err_pre", 71'(mem_err), 71'(0));
            edge_in();
        end
        check_wb("tmo_wb");
        check("tmo_err", 71'(mem_err), 71'(1));
        check("tmo_req_drop", 71'(dmem_req), 71'(0));

        // reset while a load is outstanding, ack arrives after reset
        run_mem("load_pre", 1'b0, 32'h0000_0500, 32'h0, 32'h1111_2222, 0, 5'd13);
        data_read_MEM = 1; reg_write_MEM = 1; write_Data_Src_mux_MEM = 1;
        Adderess_Datamem = 32'h0000_0400; Reg_write_num_MEM = 5'd14;
        edge_in();
        @(negedge clk);
        check("rst_busy_req", 71'(dmem_req), 71'(1));
        reset = 1;
        edge_in();
        reset = 0;
        drive_idle();
        dmem_ack = 1;
        dmem_rdata = 32'hAAAA_AAAA;
        exp_mem = 0;
        @(negedge clk);
        check("rst_wb", wb_vec(), 71'(0));
        check("rst_bus", {dmem_req, stall_MEM, mem_err}, 71'(0));
        edge_in();
        dmem_ack = 0;
        check("rst_ack_ignored", wb_vec(), 71'(0));
        check("rst_req_low", 71'(dmem_req), 71'(0));

        // misaligned load
        data_read_MEM = 1; reg_write_MEM = 1; write_Data_Src_mux_MEM = 1;
        Adderess_Datamem = 32'h0000_0102; Reg_write_num_MEM = 5'd7;
        @(negedge clk);
        check("mis_stall", 71'(stall_MEM), 71'(0));
        edge_in();
        drive_idle();
        check("mis_req", 71'(dmem_req), 71'(0));
        check("mis_err", 71'(mem_err), 71'(1));
        check("mis_bubble", 71'(reg_write_WB), 71'(0));
        edge_in();
        check("mis_err_sticky", 71'(mem_err), 71'(1));
        check("queue_empty", 71'(exp_q.size()), 71'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
